// File: rtl/phase_bus_sequencer.sv
// Phase-bus transaction engine: WRITE, READ and ADC16 transfers across N boards.
// Each board access runs SETUP, PRE, STROBE, POST and NEXT, in ascending board order.
module phase_bus_sequencer #(
    parameter int         NUM_BOARDS     = 4,
    parameter int         SETTLE_CYCLES  = 21,
    parameter int         STROBE_CYCLES  = 2,
    parameter int         CONVERT_CYCLES = 84,
    parameter logic [2:0] PORT_MUX       = 3'd3,
    parameter logic [2:0] PORT_ADC_HIGH  = 3'd4,
    parameter logic [2:0] PORT_ADC_LOW   = 3'd5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [2:0]               port_addr,
    input  logic [7:0]               mux_channel,
    input  logic [NUM_BOARDS-1:0]    board_mask,
    input  logic [8*NUM_BOARDS-1:0]  wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [16*NUM_BOARDS-1:0] rd_data,
    output logic [NUM_BOARDS-1:0]    board_x,
    output logic [2:0]               addr_port,
    output logic                     rd_p,
    output logic                     wr_p,
    output logic [7:0]               data_out,
    input  logic [7:0]               data_in,
    output logic                     data_dir
);

    localparam int MAX_SC = (SETTLE_CYCLES > CONVERT_CYCLES) ? SETTLE_CYCLES : CONVERT_CYCLES;
    localparam int MAX_W  = (MAX_SC > STROBE_CYCLES) ? MAX_SC : STROBE_CYCLES;
    localparam int CW     = $clog2(MAX_W + 1);
    localparam int BW     = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_DISPATCH, S_SETUP, S_PRE, S_STROBE,
        S_POST, S_NEXT, S_CONV_STB, S_CONV_WAIT, S_FINISH
    } state_e;

    typedef enum logic [2:0] {P_WR, P_RD, P_MUX, P_ADCH, P_ADCL} step_e;
    typedef enum logic [1:0] {M_WRITE, M_READ, M_ADC16, M_RSVD} mode_e;

    state_e                  r_state, w_state_nxt;
    step_e                   r_step, w_step_nxt;
    mode_e                   r_mode;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic [BW-1:0]           r_board, w_board_nxt;
    logic [2:0]              r_port;
    logic [7:0]              r_mux;
    logic [NUM_BOARDS-1:0]   r_mask;
    logic [8*NUM_BOARDS-1:0] r_wdata;
    logic [16*NUM_BOARDS-1:0] r_rd;

    logic [BW-1:0]         w_first, w_next;
    logic                  w_first_ok, w_next_ok;
    logic [NUM_BOARDS-1:0] w_sel;
    logic [7:0]            w_byte;
    logic [2:0]            w_port;
    logic                  w_drive, w_access, w_capture;

    assign w_sel    = NUM_BOARDS'(1) << r_board;
    assign w_byte   = r_wdata[8*int'(r_board) +: 8];
    assign w_drive  = (r_step == P_WR) || (r_step == P_MUX);
    assign w_access = (r_state == S_SETUP) || (r_state == S_PRE) ||
                      (r_state == S_STROBE) || (r_state == S_POST);
    assign rd_data  = r_rd;

    // Lowest masked board overall, and lowest masked board above the current one.
    always_comb begin
        w_first    = '0;
        w_first_ok = 1'b0;
        w_next     = '0;
        w_next_ok  = 1'b0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first    = BW'(i);
                w_first_ok = 1'b1;
                if (i > int'(r_board)) begin
                    w_next    = BW'(i);
                    w_next_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_port = r_port;
        unique case (r_step)
            P_MUX:   w_port = PORT_MUX;
            P_ADCH:  w_port = PORT_ADC_HIGH;
            P_ADCL:  w_port = PORT_ADC_LOW;
            default: w_port = r_port;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_board_nxt = r_board;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_capture   = 1'b0;
        busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
        done        = 1'b0;
        error       = 1'b0;
        board_x     = '0;
        addr_port   = '0;
        rd_p        = 1'b0;
        wr_p        = 1'b0;
        data_out    = '0;
        data_dir    = 1'b0;

        if (w_access) begin
            board_x   = (r_step == P_MUX) ? r_mask : w_sel;
            addr_port = w_port;
            data_dir  = w_drive;
            data_out  = !w_drive ? 8'h00 : ((r_step == P_MUX) ? r_mux : w_byte);
        end

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start) w_state_nxt = S_DISPATCH;
            end
            S_DISPATCH: begin
                w_cnt_nxt   = '0;
                w_board_nxt = w_first;
                if (r_mode == M_RSVD || !w_first_ok) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_SETUP;
                    unique case (r_mode)
                        M_WRITE: w_step_nxt = P_WR;
                        M_READ:  w_step_nxt = P_RD;
                        default: w_step_nxt = P_MUX;
                    endcase
                end
            end
            S_SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_PRE;
            end
            S_PRE: begin
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                wr_p = w_drive;
                rd_p = !w_drive;
                if (r_cnt == CW'(STROBE_CYCLES - 1)) begin
                    w_capture   = !w_drive;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_POST;
                end
            end
            S_POST: begin
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_step == P_MUX) ? S_CONV_STB : S_NEXT;
                end
            end
            S_CONV_STB: begin
                board_x   = r_mask;
                addr_port = PORT_MUX;
                data_out  = r_mux;
                data_dir  = 1'b1;
                wr_p      = 1'b1;
                if (r_cnt == CW'(STROBE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CONV_WAIT;
                end
            end
            S_CONV_WAIT: begin
                if (r_cnt == CW'(CONVERT_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_step_nxt  = P_ADCH;
                    w_board_nxt = w_first;
                    w_state_nxt = S_SETUP;
                end
            end
            S_NEXT: begin
                w_cnt_nxt = '0;
                // The high-byte read is always followed by the low-byte read of the same board.
                if (r_step == P_ADCH) begin
                    w_step_nxt  = P_ADCL;
                    w_state_nxt = S_SETUP;
                end else if (w_next_ok) begin
                    w_board_nxt = w_next;
                    w_step_nxt  = (r_step == P_ADCL) ? P_ADCH : r_step;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_cnt_nxt   = '0;
                done        = 1'b1;
                error       = (r_mode == M_RSVD);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_step  <= P_WR;
            r_mode  <= M_WRITE;
            r_cnt   <= '0;
            r_board <= '0;
            r_port  <= '0;
            r_mux   <= '0;
            r_mask  <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_board <= w_board_nxt;
            if (r_state == S_IDLE && start) begin
                r_mode  <= mode_e'(mode);
                r_port  <= port_addr;
                r_mux   <= mux_channel;
                r_mask  <= board_mask;
                r_wdata <= wr_data;
            end
            if (w_capture) begin
                unique case (r_step)
                    P_RD:    r_rd[16*int'(r_board) +: 16]    <= {8'h00, data_in};
                    P_ADCH:  r_rd[16*int'(r_board) + 8 +: 8] <= data_in;
                    P_ADCL:  r_rd[16*int'(r_board) +: 8]     <= data_in;
                    default: r_rd <= r_rd;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_bus_sequencer.sv
// Bench for phase_bus_sequencer: directed vector table, corner sequences and random traffic.
// Bus strobes are captured as events and compared with a transaction-level model.
module tb_phase_bus_sequencer;

    localparam int NB = 4;
    localparam int S  = 2;
    localparam int T  = 1;
    localparam int C  = 6;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      mode = '0;
    logic [2:0]      port_addr = '0;
    logic [7:0]      mux_channel = '0;
    logic [NB-1:0]   board_mask = '0;
    logic [8*NB-1:0] wr_data = '0;
    logic            busy, done, error, rd_p, wr_p, data_dir;
    logic [16*NB-1:0] rd_data;
    logic [NB-1:0]   board_x;
    logic [2:0]      addr_port;
    logic [7:0]      data_out, data_in;
    logic [7:0]      salt = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    phase_bus_sequencer #(
        .NUM_BOARDS(NB), .SETTLE_CYCLES(S), .STROBE_CYCLES(T), .CONVERT_CYCLES(C),
        .PORT_MUX(3'd3), .PORT_ADC_HIGH(3'd4), .PORT_ADC_LOW(3'd5)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .port_addr(port_addr), .mux_channel(mux_channel),
        .board_mask(board_mask), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .rd_data(rd_data),
        .board_x(board_x), .addr_port(addr_port), .rd_p(rd_p), .wr_p(wr_p),
        .data_out(data_out), .data_in(data_in), .data_dir(data_dir)
    );

    always #5 clock = ~clock;

    // Board b answers 0xA0+b on ordinary ports, 0x10+b / 0x20+b on the ADC ports.
    function automatic logic [7:0] dfun(input logic [NB-1:0] bx, input logic [2:0] a,
                                        input logic [7:0] s);
        int idx = -1;
        logic [NB-1:0] one = 1;
        logic [7:0] base;
        for (int i = 0; i < NB; i++) if (bx == (one << i)) idx = i;
        if (idx < 0) return 8'hEE;
        base = (a == 3'd4) ? 8'h10 : (a == 3'd5) ? 8'h20 : 8'hA0;
        return (base + 8'(idx)) ^ s;
    endfunction

    always_comb data_in = dfun(board_x, addr_port, salt);

    typedef struct packed {
        logic          wr;
        logic [NB-1:0] bx;
        logic [2:0]    addr;
        logic [7:0]    dout;
        logic          dir;
    } ev_t;

    ev_t  got_q[$];
    ev_t  exp_q[$];
    ev_t  mon_e;
    int   viol = 0, stb_cyc = 0, done_cnt = 0, stable = 0;
    logic prev_stb = 1'b0;
    logic [NB+2:0] prev_ba = '0;

    always @(negedge clock) begin
        if (rd_p && wr_p) viol++;
        if ((rd_p || wr_p) && board_x == '0) viol++;
        if ({board_x, addr_port} == prev_ba) stable++;
        else stable = 0;
        if ((rd_p || wr_p) && !prev_stb) begin
            if (stable < S) viol++;
            mon_e.wr   = wr_p;
            mon_e.bx   = board_x;
            mon_e.addr = addr_port;
            mon_e.dout = wr_p ? data_out : 8'h00;
            mon_e.dir  = data_dir;
            got_q.push_back(mon_e);
        end
        if (rd_p || wr_p) stb_cyc++;
        if (done) done_cnt++;
        prev_stb = rd_p | wr_p;
        prev_ba  = {board_x, addr_port};
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [16*NB-1:0] mrd = '0;

    task automatic push_ev(input logic w, input logic [NB-1:0] bx, input logic [2:0] a,
                           input logic [7:0] d);
        ev_t e;
        e.wr = w; e.bx = bx; e.addr = a; e.dout = w ? d : 8'h00; e.dir = w;
        exp_q.push_back(e);
    endtask

    // Transaction-level model: expected strobe list, completion latency, result buffer.
    task automatic model(input logic [1:0] m, input logic [2:0] p, input logic [7:0] mx,
                         input logic [NB-1:0] mk, input logic [8*NB-1:0] wd, output int lat);
        int n = $countones(mk);
        int acc = 2*S + T + 2;
        logic [NB-1:0] one = 1;
        exp_q.delete();
        lat = 2;
        if (m == 2'd3 || n == 0) return;
        if (m == 2'd2) begin
            lat = 2 + (1 + 2*S + T) + T + C + 2*n*acc;
            push_ev(1'b1, mk, 3'd3, mx);
            push_ev(1'b1, mk, 3'd3, mx);
        end else begin
            lat = 2 + n*acc;
        end
        for (int b = 0; b < NB; b++) begin
            if (mk[b]) begin
                if (m == 2'd0) push_ev(1'b1, one << b, p, wd[8*b +: 8]);
                else if (m == 2'd1) begin
                    push_ev(1'b0, one << b, p, 8'h00);
                    mrd[16*b +: 16] = {8'h00, dfun(one << b, p, salt)};
                end else begin
                    push_ev(1'b0, one << b, 3'd4, 8'h00);
                    push_ev(1'b0, one << b, 3'd5, 8'h00);
                    mrd[16*b +: 16] = {dfun(one << b, 3'd4, salt), dfun(one << b, 3'd5, salt)};
                end
            end
        end
    endtask

    task automatic run_txn(input logic [1:0] m, input logic [2:0] p, input logic [7:0] mx,
                           input logic [NB-1:0] mk, input logic [8*NB-1:0] wd,
                           output int lat, output logic err);
        int base_ev  = got_q.size();
        int base_stb = stb_cyc;
        int base_v   = viol;
        int busy_bad = 0;
        int mlat;
        model(m, p, mx, mk, wd, mlat);
        @(posedge clock); #1;
        mode = m; port_addr = p; mux_channel = mx; board_mask = mk; wr_data = wd;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            if (!busy) busy_bad++;
            @(posedge clock); #1;
            lat++;
        end
        chk("done_seen", done, 1'b1);
        err = error;
        chk("error_flag", error, (m == 2'd3));
        chk("busy_at_done", busy, 1'b0);
        chk("busy_during", busy_bad, 0);
        chk("latency_model", lat, mlat);
        @(posedge clock); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("event_count", got_q.size() - base_ev, exp_q.size());
        for (int i = 0; i < exp_q.size() && base_ev + i < got_q.size(); i++)
            chk("event", got_q[base_ev + i], exp_q[i]);
        chk("strobe_cycles", stb_cyc - base_stb, exp_q.size() * T);
        chk("bus_invariants", viol - base_v, 0);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [2:0]  p;
        logic [7:0]  mx;
        logic [3:0]  mk;
        logic [31:0] wd;
        int          lat;
        logic        err;
        logic [63:0] rd;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int   lat, base_d, base_e, guard;
        logic err, found;

        tbl[0] = '{2'd0, 3'd2, 8'h00, 4'b1111, 32'h44332211, 30, 1'b0, 64'h0};
        tbl[1] = '{2'd1, 3'd1, 8'h00, 4'b1010, 32'h0, 16, 1'b0, 64'h00A3_0000_00A1_0000};
        tbl[2] = '{2'd2, 3'd0, 8'h07, 4'b0101, 32'h0, 43, 1'b0, 64'h00A3_1222_00A1_1020};
        tbl[3] = '{2'd1, 3'd1, 8'h00, 4'b0000, 32'h0, 2, 1'b0, 64'h00A3_1222_00A1_1020};
        tbl[4] = '{2'd3, 3'd1, 8'h00, 4'b1111, 32'h0, 2, 1'b1, 64'h00A3_1222_00A1_1020};
        tbl[5] = '{2'd0, 3'd6, 8'h00, 4'b1000, 32'hDEADBEEF, 9, 1'b0, 64'h00A3_1222_00A1_1020};

        #3;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_error", error, 1'b0);
        chk("reset_strobes", {rd_p, wr_p, data_dir}, 3'b000);
        chk("reset_board_x", board_x, '0);
        chk("reset_addr_data", {addr_port, data_out}, 11'h0);
        chk("reset_rd_data", rd_data, '0);
        #19 reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].m, tbl[i].p, tbl[i].mx, tbl[i].mk, tbl[i].wd, lat, err);
            chk("vec_latency", lat, tbl[i].lat);
            chk("vec_error", err, tbl[i].err);
            chk("vec_rd_data", rd_data, tbl[i].rd);
        end

        // start held high: accepted once, then again only after returning to IDLE
        base_d = done_cnt; base_e = got_q.size();
        @(posedge clock); #1;
        mode = 2'd0; port_addr = 3'd2; board_mask = 4'b0001; wr_data = 32'h55;
        start = 1'b1;
        repeat (12) @(posedge clock);
        #1 start = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        chk("held_start_dones", done_cnt - base_d, 2);
        chk("held_start_strobes", got_q.size() - base_e, 2);

        // start pulsed while busy is ignored
        base_d = done_cnt; base_e = got_q.size();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        chk("busy_start_dones", done_cnt - base_d, 1);
        chk("busy_start_strobes", got_q.size() - base_e, 1);
        chk("overlap_total", viol, 0);

        // asynchronous reset in the middle of board 2's read strobe
        @(posedge clock); #1;
        mode = 2'd1; port_addr = 3'd1; board_mask = 4'b1111; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        found = 1'b0; guard = 0;
        while (!found && guard < 100) begin
            @(posedge clock); #1;
            guard++;
            if (rd_p && board_x == 4'b0100) found = 1'b1;
        end
        chk("reach_board2_strobe", found, 1'b1);
        base_d = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("async_rd_p", rd_p, 1'b0);
        chk("async_board_x", board_x, '0);
        chk("async_busy", busy, 1'b0);
        chk("async_rd_data", rd_data, '0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("no_done_after_reset", done_cnt - base_d, 0);
        mrd = '0;
        salt = 8'h5A;
        run_txn(2'd1, 3'd2, 8'h00, 4'b0110, 32'h0, lat, err);
        chk("post_reset_rd_data", rd_data, mrd);

        for (int k = 0; k < 30; k++) begin
            salt = 8'($urandom);
            run_txn(2'($urandom_range(0, 3)), 3'($urandom), 8'($urandom),
                    4'($urandom_range(0, 15)), 32'($urandom), lat, err);
            chk("rand_rd_data", rd_data, mrd);
        end

        chk("final_invariants", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_bus_sequencer.md
Name: phase_bus_sequencer

Overview:
Parametrised phase-bus transaction engine that generalises the fixed 4-card write/read sequencers to N boards, with a per-transaction board mask and a 16-bit ADC mode. Sits between the command decoder and the phase-bus pins. A single start/busy/done handshake runs one bus transaction: write-all, read-all, or ADC16, which is a mux write, a convert strobe, then high and low byte reads per board. Read results are returned in a packed buffer for the UART response formatter.

Parameters:
NUM_BOARDS, 4, number of phase-bus cards (1..8); width of board_x and board_mask
SETTLE_CYCLES, 21, clocks of address/data setup before a strobe and hold after it (≈777 ns at 27 MHz)
STROBE_CYCLES, 2, clocks rd_p/wr_p is held active
CONVERT_CYCLES, 84, clocks waited after the ADC convert strobe before the first read
PORT_MUX, 3'd3, port address of the analog mux latch
PORT_ADC_HIGH, 3'd4, port address of the ADC high byte
PORT_ADC_LOW, 3'd5, port address of the ADC low byte

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin transaction; sampled only in IDLE
mode  in  2  0=WRITE, 1=READ, 2=ADC16, 3=reserved
port_addr  in  3  port address for WRITE/READ
mux_channel  in  8  mux latch value for ADC16
board_mask  in  NUM_BOARDS  bit b=1 includes board b
wr_data  in  8*NUM_BOARDS  WRITE byte for board b at [8b+7:8b]
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at completion
error  out  1  one-cycle pulse with done when mode=3
rd_data  out  16*NUM_BOARDS  per-board result at [16b+15:16b]
board_x  out  NUM_BOARDS  board select, active-high
addr_port  out  3  bus port address
rd_p  out  1  read strobe, active-high
wr_p  out  1  write strobe, active-high
data_out  out  8  bus write data
data_in  in  8  bus read data
data_dir  out  1  1=drive bus (output), 0=input

Behaviour:
- Reset (asynchronous, any state): go to IDLE. board_x=0, addr_port=0, rd_p=0, wr_p=0, data_out=0, data_dir=0, busy=0, done=0, error=0, rd_data=0. A transaction in flight is abandoned with no done pulse.
- IDLE: a start pulse latches mode, port_addr, mux_channel, board_mask and wr_data. busy=1 from the next cycle. start is ignored while busy.
- Board access (one selected board b, for WRITE and READ) runs these phases:
  - SETUP, 1 clk: board_x=1<<b, addr_port set, strobes low, data_dir=1 with data_out=byte b (WRITE) or data_dir=0 (READ).
  - PRE, SETTLE_CYCLES clks: outputs held.
  - STROBE, STROBE_CYCLES clks: wr_p or rd_p =1. READ captures data_in on the last strobe cycle.
  - POST, SETTLE_CYCLES clks: strobe=0, board_x and addr_port held.
  - NEXT, 1 clk: board_x=0. Advances to the lowest-index masked board above b, or to FINISH.
- WRITE: board accesses in ascending index order, masked boards only. data_dir returns to 0 in NEXT.
- READ: same ordering. rd_data[16b+7:16b] gets the captured byte and [16b+15:16b+8] is set to 0.
- ADC16:
  - Mux phase: board_x=board_mask (all masked boards at once), addr_port=PORT_MUX, data_out=mux_channel, data_dir=1. Runs SETUP/PRE/STROBE(wr_p)/POST.
  - Convert: wr_p strobe again with the same selection, STROBE_CYCLES long. Then data_dir=0, board_x=0, and a wait of CONVERT_CYCLES.
  - Per masked board, ascending: a READ access at PORT_ADC_HIGH into [16b+15:16b+8], then one at PORT_ADC_LOW into [16b+7:16b].
- Slots of unmasked boards keep their previous rd_data. WRITE leaves rd_data unchanged.
- FINISH, 1 clk: done=1, busy=0, all strobes/selects=0, data_dir=0. Return to IDLE; a new start is accepted the cycle after.
- Empty mask in any valid mode: no bus activity, done 2 clks after start.
- mode=3: done=1 and error=1 2 clks after start, no bus activity.
- rd_p and wr_p are never both high. A strobe is high only while board_x≠0 and after ≥SETTLE_CYCLES of stable address.
- Wait counters are sized $clog2(max(SETTLE_CYCLES, CONVERT_CYCLES)+1) and reset to 0 on every phase entry.

Test Plan:
1. NUM_BOARDS=4, SETTLE=2, STROBE=1, WRITE, mask=4'b1111, port=2, wr_data=0x44332211 -> board_x 1,2,4,8 in turn, data_out 0x11..0x44, wr_p one clk each, 7 clks per board, done at cycle 30.
2. READ, mask=4'b1010, data_in model returns 0xA0+b -> only boards 1 and 3 are strobed; rd_data[31:16]=0x00A1, [63:48]=0x00A3, slots 0 and 2 unchanged.
3. ADC16, mask=4'b0101, mux_channel=0x07, model returns high=0x1b, low=0x2b -> one wr_p with board_x=4'b0101, addr=3, data_out=0x07, then the convert wr_p. After CONVERT_CYCLES, reads at 4 then 5 per board: rd_data[15:0]=0x1020, [47:32]=0x1222.
4. mask=0 -> no strobe, done 2 clks after start. mode=3 -> done and error pulse together.
5. Assert reset during STROBE of board 2 in a READ -> rd_p, board_x and busy drop asynchronously, no done pulse, rd_data=0. A fresh start then completes normally.
6. start held high through a transaction, plus start during busy -> exactly one transaction per acceptance in IDLE. Check rd_p&wr_p==0 throughout.
